// File: rtl/riscv_pkg.sv
// riscv_pkg: shared XLEN, arbiter owner enum and memory request struct
package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic {OWNER_CORE = 1'b0, OWNER_DBG = 1'b1} arb_owner_e;
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
  } mem_req_t;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin core/debug arbiter onto one data memory port (core_*, dbg_* requesters; mem_* memory; conflict_cnt_o status)
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int MEM_SIZE = 2048,
  parameter int CNT_W    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        core_req_i,
  input  logic                        core_we_i,
  input  logic [XLEN-1:0]             core_addr_i,
  input  logic [XLEN-1:0]             core_wdata_i,
  input  logic [3:0]                  core_be_i,
  output logic                        core_gnt_o,
  output logic                        core_rvalid_o,
  output logic                        core_err_o,
  output logic [XLEN-1:0]             core_rdata_o,
  input  logic                        dbg_req_i,
  input  logic                        dbg_we_i,
  input  logic [XLEN-1:0]             dbg_addr_i,
  input  logic [XLEN-1:0]             dbg_wdata_i,
  input  logic [3:0]                  dbg_be_i,
  output logic                        dbg_gnt_o,
  output logic                        dbg_rvalid_o,
  output logic                        dbg_err_o,
  output logic [XLEN-1:0]             dbg_rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr_o,
  output logic [XLEN-1:0]             mem_wdata_o,
  output logic [3:0]                  mem_be_o,
  input  logic [XLEN-1:0]             mem_rdata_i,
  output logic [CNT_W-1:0]            conflict_cnt_o
);
  localparam int AW = $clog2(MEM_SIZE);
  logic            prio_q, rsp_valid_q, rsp_err_q, rsp_we_q, any_gnt, sel_err;
  arb_owner_e      rsp_owner_q;
  mem_req_t        sel;
  logic [XLEN-1:0] widx, rd;
  always_comb begin
    core_gnt_o    = !rst_i && core_req_i && (!dbg_req_i || !prio_q);
    dbg_gnt_o     = !rst_i && dbg_req_i && (!core_req_i || prio_q);
    any_gnt       = core_gnt_o || dbg_gnt_o;
    sel           = dbg_gnt_o ? {dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_be_i}
                              : {core_we_i, core_addr_i, core_wdata_i, core_be_i};
    widx          = sel.addr >> 2;
    sel_err       = (widx >> AW) != '0;
    mem_req_o     = any_gnt && !sel_err;
    mem_we_o      = mem_req_o && sel.we;
    mem_addr_o    = mem_req_o ? widx[AW-1:0] : '0;
    mem_wdata_o   = mem_req_o ? sel.wdata : '0;
    mem_be_o      = mem_req_o ? sel.be : '0;
    rd            = (rsp_err_q || rsp_we_q) ? '0 : mem_rdata_i;
    core_rvalid_o = rsp_valid_q && rsp_owner_q == OWNER_CORE;
    dbg_rvalid_o  = rsp_valid_q && rsp_owner_q == OWNER_DBG;
    core_err_o    = core_rvalid_o && rsp_err_q;
    dbg_err_o     = dbg_rvalid_o && rsp_err_q;
    core_rdata_o  = core_rvalid_o ? rd : '0;
    dbg_rdata_o   = dbg_rvalid_o ? rd : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q         <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_owner_q    <= OWNER_CORE;
      rsp_err_q      <= 1'b0;
      rsp_we_q       <= 1'b0;
      conflict_cnt_o <= '0;
    end else begin
      prio_q      <= core_gnt_o ? 1'b1 : dbg_gnt_o ? 1'b0 : prio_q;
      rsp_valid_q <= any_gnt;
      rsp_owner_q <= dbg_gnt_o ? OWNER_DBG : OWNER_CORE;
      rsp_err_q   <= sel_err;
      rsp_we_q    <= sel.we;
      if (core_req_i && dbg_req_i && !(&conflict_cnt_o)) conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven and scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  import riscv_pkg::*;
  logic        clk = 1'b0, rst = 1'b1;
  logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0]  c_be = 4'hF, d_be = 4'hF;
  logic        c_gnt, c_rv, c_err, d_gnt, d_rv, d_err, m_req, m_we;
  logic [31:0] c_rdata, d_rdata, m_wdata;
  logic [10:0] m_addr;
  logic [3:0]  m_be;
  logic [15:0] cnt;
  logic        x_cg, x_crv, x_cerr, x_dg, x_drv, x_derr, x_mreq, x_mwe;
  logic [31:0] x_crd, x_drd, x_mwd;
  logic [10:0] x_maddr;
  logic [3:0]  x_mbe;
  logic [1:0]  cnt2;
  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_SIZE(2048), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(c_req), .core_we_i(c_we), .core_addr_i(c_addr), .core_wdata_i(c_wdata), .core_be_i(c_be),
    .core_gnt_o(c_gnt), .core_rvalid_o(c_rv), .core_err_o(c_err), .core_rdata_o(c_rdata),
    .dbg_req_i(d_req), .dbg_we_i(d_we), .dbg_addr_i(d_addr), .dbg_wdata_i(d_wdata), .dbg_be_i(d_be),
    .dbg_gnt_o(d_gnt), .dbg_rvalid_o(d_rv), .dbg_err_o(d_err), .dbg_rdata_o(d_rdata),
    .mem_req_o(m_req), .mem_we_o(m_we), .mem_addr_o(m_addr), .mem_wdata_o(m_wdata), .mem_be_o(m_be),
    .mem_rdata_i(mem_rdata), .conflict_cnt_o(cnt));

  dmem_arbiter #(.MEM_SIZE(2048), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(c_req), .core_we_i(c_we), .core_addr_i(c_addr), .core_wdata_i(c_wdata), .core_be_i(c_be),
    .core_gnt_o(x_cg), .core_rvalid_o(x_crv), .core_err_o(x_cerr), .core_rdata_o(x_crd),
    .dbg_req_i(d_req), .dbg_we_i(d_we), .dbg_addr_i(d_addr), .dbg_wdata_i(d_wdata), .dbg_be_i(d_be),
    .dbg_gnt_o(x_dg), .dbg_rvalid_o(x_drv), .dbg_err_o(x_derr), .dbg_rdata_o(x_drd),
    .mem_req_o(x_mreq), .mem_we_o(x_mwe), .mem_addr_o(x_maddr), .mem_wdata_o(x_mwd), .mem_be_o(x_mbe),
    .mem_rdata_i(mem_rdata), .conflict_cnt_o(cnt2));

  logic [31:0] mem_m [0:2047];
  always @(posedge clk) if (m_req) begin
    if (m_we) mem_m[m_addr] <= m_wdata;
    mem_rdata <= mem_m[m_addr];
  end

  typedef struct {bit c; bit d; bit err; logic [31:0] rdata;} rsp_t;
  typedef struct {bit cr; bit cwe; logic [31:0] ca; bit dr; bit dwe; logic [31:0] da; bit ecg; bit edg; bit emr;} vec_t;
  rsp_t q[$];
  vec_t tv[12];
  int   checks = 0, errors = 0;
  bit   prio_m = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    c_req = 0; d_req = 0; rst = 1;
    q.delete(); prio_m = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic step(input bit cr, input bit cwe, input logic [31:0] ca, input logic [31:0] cd,
                      input bit dr, input bit dwe, input logic [31:0] da, input logic [31:0] dd,
                      output bit sg_c, output bit sg_d, output bit sm_req);
    rsp_t e;
    bit eg_c, eg_d, werr, wwe;
    logic [31:0] wa, wd;
    c_req = cr; c_we = cwe; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dd;
    @(negedge clk);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("core_rvalid", 32'(c_rv), 32'(e.c));
      chk("dbg_rvalid", 32'(d_rv), 32'(e.d));
      chk("core_err", 32'(c_err), 32'(e.c && e.err));
      chk("dbg_err", 32'(d_err), 32'(e.d && e.err));
      chk("core_rdata", c_rdata, e.c ? e.rdata : 32'h0);
      chk("dbg_rdata", d_rdata, e.d ? e.rdata : 32'h0);
    end else begin
      chk("core_rvalid_idle", 32'(c_rv), 32'h0);
      chk("dbg_rvalid_idle", 32'(d_rv), 32'h0);
    end
    eg_c = cr && (!dr || !prio_m);
    eg_d = dr && !eg_c;
    wa   = eg_d ? da : ca;
    wd   = eg_d ? dd : cd;
    wwe  = eg_d ? dwe : cwe;
    werr = (wa >> 13) != 0;
    sg_c = c_gnt; sg_d = d_gnt; sm_req = m_req;
    chk("core_gnt", 32'(c_gnt), 32'(eg_c));
    chk("dbg_gnt", 32'(d_gnt), 32'(eg_d));
    chk("mem_req", 32'(m_req), 32'((eg_c || eg_d) && !werr));
    if ((eg_c || eg_d) && !werr) begin
      chk("mem_addr", 32'(m_addr), 32'(wa[12:2]));
      chk("mem_we", 32'(m_we), 32'(wwe));
      chk("mem_wdata", m_wdata, wd);
    end
    if (eg_c || eg_d) begin
      e.c = eg_c; e.d = eg_d; e.err = werr;
      e.rdata = (werr || wwe) ? 32'h0 : mem_m[wa[12:2]];
      q.push_back(e);
    end
    if (eg_c) prio_m = 1;
    else if (eg_d) prio_m = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit g_c, g_d, g_m;
    tv[0]  = '{1, 0, 32'h20, 1, 0, 32'h24, 1, 0, 1};
    tv[1]  = '{1, 0, 32'h20, 1, 0, 32'h24, 0, 1, 1};
    tv[2]  = '{1, 0, 32'h20, 1, 0, 32'h24, 1, 0, 1};
    tv[3]  = '{1, 0, 32'h20, 1, 0, 32'h24, 0, 1, 1};
    tv[4]  = '{1, 1, 32'h30, 1, 0, 32'h34, 1, 0, 1};
    tv[5]  = '{1, 0, 32'h30, 0, 0, 32'h0, 1, 0, 1};
    tv[6]  = '{0, 0, 32'h0, 1, 0, 32'h40, 0, 1, 1};
    tv[7]  = '{0, 0, 32'h0, 1, 0, 32'h44, 0, 1, 1};
    tv[8]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0};
    tv[9]  = '{0, 0, 32'h0, 1, 1, 32'h2000, 0, 1, 0};
    tv[10] = '{1, 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 1, 0, 0};
    tv[11] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0};
    c_req = 1; d_req = 1;
    #2;
    chk("rst_core_gnt", 32'(c_gnt), 32'h0);
    chk("rst_dbg_gnt", 32'(d_gnt), 32'h0);
    chk("rst_mem_req", 32'(m_req), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    do_reset();
    step(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, g_c, g_d, g_m);
    step(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, g_c, g_d, g_m);
    chk("read_same_cycle_gnt", 32'(g_c), 32'h1);
    chk("read_rvalid", 32'(c_rv), 32'h1);
    chk("read_rdata", c_rdata, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, g_c, g_d, g_m);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tv[i].cr, tv[i].cwe, tv[i].ca, tv[i].ca ^ 32'h1111_0000,
           tv[i].dr, tv[i].dwe, tv[i].da, tv[i].da ^ 32'h2222_0000, g_c, g_d, g_m);
      chk($sformatf("tv%0d_core_gnt", i), 32'(g_c), 32'(tv[i].ecg));
      chk($sformatf("tv%0d_dbg_gnt", i), 32'(g_d), 32'(tv[i].edg));
      chk($sformatf("tv%0d_mem_req", i), 32'(g_m), 32'(tv[i].emr));
      if (i == 3) chk("conflict_cnt_4", 32'(cnt), 32'd4);
      if (i == 9) begin
        chk("oor_dbg_rvalid", 32'(d_rv), 32'h1);
        chk("oor_dbg_err", 32'(d_err), 32'h1);
        chk("oor_dbg_rdata", d_rdata, 32'h0);
      end
    end
    chk("conflict_cnt_5", 32'(cnt), 32'd5);
    chk("conflict_cnt_sat", 32'(cnt2), 32'd3);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 0, 0, 0, 0, g_c, g_d, g_m);
      chk($sformatf("burst%0d_rvalid", i), 32'(c_rv), 32'h1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, g_c, g_d, g_m);
    step(1, 0, 32'h104, 32'h0, 0, 0, 0, 0, g_c, g_d, g_m);
    rst = 1;
    #1;
    chk("rst_drops_rvalid", 32'(c_rv), 32'h0);
    q.delete(); prio_m = 0;
    c_req = 0; d_req = 0;
    @(posedge clk); #1;
    chk("rst_hold_rvalid", 32'(c_rv), 32'h0);
    rst = 0;
    step(1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0, g_c, g_d, g_m);
    chk("post_rst_core_wins", 32'(g_c), 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, g_c, g_d, g_m);
    step(0, 0, 0, 0, 0, 0, 0, 0, g_c, g_d, g_m);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 2048, data memory depth in 32-bit words.
REQ-002 Parameter CNT_W, default 16, width of the conflict counter.
REQ-003 Clocking: one clock; reset is asynchronous and active-high. Ports: clk_i  in  1  clock; rst_i  in  1  async active-high reset.
REQ-004 Core port: core_req_i in 1; core_we_i in 1; core_addr_i in XLEN (byte address); core_wdata_i in XLEN; core_be_i in 4; core_gnt_o out 1; core_rvalid_o out 1; core_err_o out 1; core_rdata_o out XLEN.
REQ-005 Debug port: dbg_* with the same signals, widths and meanings as the core port.
REQ-006 Memory port: mem_req_o out 1; mem_we_o out 1; mem_addr_o out $clog2(MEM_SIZE) (word index); mem_wdata_o out XLEN; mem_be_o out 4; mem_rdata_i in XLEN (valid exactly 1 cycle after mem_req_o).
REQ-007 Status: conflict_cnt_o out CNT_W, number of cycles in which both ports requested.

Function
REQ-008 A request is transferred in any cycle where req and gnt are both 1; gnt is combinational from req and the priority state.
REQ-009 Only one of core_gnt_o and dbg_gnt_o shall be 1 per cycle; gnt shall be 0 while the matching req is 0.
REQ-010 A lone requester shall be granted in the same cycle, regardless of priority.
REQ-011 Round-robin arbitration: a 1-bit priority register prio_q (0=core, 1=dbg) selects the winner when both request; after any grant, prio_q shall point to the non-granted port.
REQ-012 Word index = addr[$clog2(MEM_SIZE)+1:2]; addr[1:0] is ignored.
REQ-013 Range check: an address with any bit above bit $clog2(MEM_SIZE)+1 set is an error; it is still granted, mem_req_o stays 0 and no memory write occurs.
REQ-014 For a granted in-range request, mem_req_o=1 and mem_we_o/addr/wdata/be are taken from the winner in the same cycle; mem_* outputs are 0 when there is no grant.
REQ-015 Response: exactly 1 cycle after each grant, the granted port's rvalid shall be 1 for one cycle, for reads and for writes.
REQ-016 rdata = mem_rdata_i for in-range reads, 0 for writes and errors; err = 1 only for range errors.
REQ-017 The response register (rsp_valid_q, rsp_owner_q, rsp_err_q, rsp_we_q) shall allow back-to-back grants every cycle with no bubble.
REQ-018 The non-owning port's rvalid, err and rdata shall be 0.
REQ-019 conflict_cnt_o increments when core_req_i and dbg_req_i are both 1, saturates at all-ones and does not wrap.

Reset
REQ-020 On rst_i assertion: prio_q=0, response register cleared, conflict_cnt_o=0, and all gnt/rvalid/err/rdata/mem_* outputs 0 immediately (asynchronously).
REQ-021 A response pending when reset asserts is dropped; no rvalid shall appear after reset for a pre-reset grant.
REQ-022 On the first cycle after reset deasserts, the core wins a simultaneous request.

Structure
REQ-023 XLEN and typedef arb_owner_e (OWNER_CORE, OWNER_DBG) live in riscv_pkg; a typedef mem_req_t struct (we, addr, wdata, be) is added to riscv_pkg.
REQ-024 Single flat module; no sub-module.

Verification
REQ-025 Core-only read, addr 0x0000_0010, mem_rdata_i=0xDEAD_BEEF -> core_gnt_o=1 same cycle, mem_addr_o=4, core_rvalid_o=1 next cycle with rdata 0xDEAD_BEEF.
REQ-026 Both ports request for 4 cycles from reset -> grant order core, dbg, core, dbg; conflict_cnt_o=4.
REQ-027 Debug write, addr 0x0000_2000 (MEM_SIZE 2048) -> dbg_gnt_o=1, mem_req_o=0, next cycle dbg_rvalid_o=1, dbg_err_o=1, rdata 0.
REQ-028 Core writes every cycle for 8 cycles -> 8 grants, 8 consecutive rvalids offset by 1 cycle, no bubbles.
REQ-029 rst_i asserted in the cycle after a core read grant -> core_rvalid_o stays 0; after release, prio_q=0.
REQ-030 CNT_W=2 with 5 conflict cycles -> conflict_cnt_o saturates at 3.
